// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card/PIN tracking with retry lockout, inactivity timeout,
// and a single-outstanding start/done handshake to the transaction datapath.
module atm_session_ctrl #(
   parameter int unsigned PIN_W       = 16,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             card_in,
   input  logic             pin_valid,
   input  logic [PIN_W-1:0] pin_entry,
   input  logic [PIN_W-1:0] stored_pin,
   input  logic             op_valid,
   input  logic [2:0]       opcode,
   input  logic             more_valid,
   input  logic             another_txn,
   input  logic             txn_done,
   output logic             txn_start,
   output logic [2:0]       txn_opcode,
   output logic             session_active,
   output logic             pin_error,
   output logic             timeout,
   output logic             eject_card,
   output logic             card_retained
);

   localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC);
   localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
   localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);

   typedef enum logic [2:0] {
      IDLE, PIN_WAIT, MENU, BUSY, ASK_MORE, EJECT, LOCKED
   } state_t;

   state_t             state;
   logic [TIMER_W-1:0] timer;
   logic [TRIES_W-1:0] tries;
   logic               card_gone;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         timer          <= '0;
         tries          <= '0;
         card_gone      <= 1'b0;
         txn_start      <= 1'b0;
         txn_opcode     <= '0;
         session_active <= 1'b0;
         pin_error      <= 1'b0;
         timeout        <= 1'b0;
         eject_card     <= 1'b0;
         card_retained  <= 1'b0;
      end else begin
         txn_start  <= 1'b0;
         pin_error  <= 1'b0;
         timeout    <= 1'b0;
         eject_card <= 1'b0;
         case (state)
            IDLE: begin
               if (card_in) begin
                  state          <= PIN_WAIT;
                  session_active <= 1'b1;
                  tries          <= '0;
                  timer          <= '0;
               end
            end
            // Waiting states share priority: removal, then accepted input, then expiry.
            PIN_WAIT, MENU, ASK_MORE: begin
               if (!card_in) begin
                  state          <= IDLE;
                  session_active <= 1'b0;
                  timer          <= '0;
               end else if (state == PIN_WAIT && pin_valid) begin
                  timer <= '0;
                  if (pin_entry == stored_pin) begin
                     state <= MENU;
                  end else begin
                     pin_error <= 1'b1;
                     if (tries == TRIES_LAST) begin
                        tries          <= TRIES_W'(MAX_TRIES);
                        state          <= LOCKED;
                        session_active <= 1'b0;
                        card_retained  <= 1'b1;
                     end else begin
                        tries <= tries + TRIES_W'(1);
                     end
                  end
               end else if (state == MENU && op_valid && opcode <= 3'd5) begin
                  timer <= '0;
                  if (opcode == 3'd0) begin
                     state          <= EJECT;
                     eject_card     <= 1'b1;
                     session_active <= 1'b0;
                  end else begin
                     state      <= BUSY;
                     txn_start  <= 1'b1;
                     txn_opcode <= opcode;
                     card_gone  <= 1'b0;
                  end
               end else if (state == ASK_MORE && more_valid) begin
                  timer <= '0;
                  if (another_txn) begin
                     state <= MENU;
                  end else begin
                     state          <= EJECT;
                     eject_card     <= 1'b1;
                     session_active <= 1'b0;
                  end
               end else if (timer == TIMER_LAST) begin
                  state          <= EJECT;
                  timeout        <= 1'b1;
                  eject_card     <= 1'b1;
                  session_active <= 1'b0;
                  timer          <= '0;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            // Removal during a transaction is remembered so done can skip ASK_MORE.
            BUSY: begin
               timer <= '0;
               if (!card_in) card_gone <= 1'b1;
               if (txn_done) begin
                  card_gone <= 1'b0;
                  if (card_gone || !card_in) begin
                     state          <= IDLE;
                     session_active <= 1'b0;
                  end else begin
                     state <= ASK_MORE;
                  end
               end
            end
            EJECT: begin
               if (!card_in) state <= IDLE;
            end
            LOCKED: begin
               card_retained <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: expected output pulses are queued with their
// due cycle when stimulus is driven and matched as the DUT emits them.
module tb_atm_session_ctrl;

   localparam int unsigned PIN_W = 16;
   localparam int unsigned TCYC  = 16;
   localparam logic [3:0] KS = 4'b1000;  // txn_start
   localparam logic [3:0] KP = 4'b0100;  // pin_error
   localparam logic [3:0] KT = 4'b0010;  // timeout
   localparam logic [3:0] KE = 4'b0001;  // eject_card
   localparam logic [PIN_W-1:0] GOOD = 16'h1234;
   localparam logic [PIN_W-1:0] BAD  = 16'h0001;

   logic             clk = 1'b0;
   logic             reset;
   logic             card_in, pin_valid, op_valid, more_valid, another_txn, txn_done;
   logic [PIN_W-1:0] pin_entry, stored_pin;
   logic [2:0]       opcode;
   logic             txn_start, session_active, pin_error, timeout, eject_card, card_retained;
   logic [2:0]       txn_opcode;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   bit          mon_en = 1'b0;
   logic [63:0] sb[$];
   logic [3:0]  mk;

   atm_session_ctrl #(.PIN_W(PIN_W), .MAX_TRIES(3), .TIMEOUT_CYC(TCYC)) dut (
      .clk(clk), .reset(reset), .card_in(card_in), .pin_valid(pin_valid),
      .pin_entry(pin_entry), .stored_pin(stored_pin), .op_valid(op_valid),
      .opcode(opcode), .more_valid(more_valid), .another_txn(another_txn),
      .txn_done(txn_done), .txn_start(txn_start), .txn_opcode(txn_opcode),
      .session_active(session_active), .pin_error(pin_error), .timeout(timeout),
      .eject_card(eject_card), .card_retained(card_retained)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] ev(input logic [3:0] k, input logic [2:0] o, input int c);
      return {25'd0, k, o, c};
   endfunction

   // Every output pulse must match the oldest queued expectation, including its cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         mk = {txn_start, pin_error, timeout, eject_card};
         if (mk != 4'b0) begin
            if (sb.size() == 0)
               check("unexpected_pulse", ev(mk, txn_start ? txn_opcode : 3'd0, cyc), '0);
            else
               check("pulse", ev(mk, txn_start ? txn_opcode : 3'd0, cyc), sb.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ev(input logic [3:0] k, input logic [2:0] o, input int d);
      sb.push_back(ev(k, o, cyc + d));
   endtask

   task automatic insert();
      card_in = 1'b1;
      tick(1);
   endtask

   task automatic pin(input logic [PIN_W-1:0] p);
      pin_entry = p; pin_valid = 1'b1;
      tick(1);
      pin_valid = 1'b0;
   endtask

   task automatic op(input logic [2:0] o);
      opcode = o; op_valid = 1'b1;
      tick(1);
      op_valid = 1'b0;
   endtask

   task automatic more(input logic a);
      another_txn = a; more_valid = 1'b1;
      tick(1);
      more_valid = 1'b0;
   endtask

   task automatic done();
      txn_done = 1'b1;
      tick(1);
      txn_done = 1'b0;
   endtask

   function automatic logic [63:0] outs();
      return {55'd0, txn_start, txn_opcode, session_active, pin_error, timeout,
              eject_card, card_retained};
   endfunction

   initial begin
      reset = 1'b1; card_in = 1'b0; pin_valid = 1'b0; op_valid = 1'b0;
      more_valid = 1'b0; another_txn = 1'b0; txn_done = 1'b0;
      pin_entry = '0; stored_pin = GOOD; opcode = '0;
      tick(2);
      check("reset_outputs", outs(), '0);
      reset = 1'b0;
      mon_en = 1'b1;

      // Normal session: one transaction, then finish and eject.
      insert();
      check("t1_active_pinwait", {63'd0, session_active}, 64'd1);
      pin(GOOD);
      check("t1_active_menu", {63'd0, session_active}, 64'd1);
      expect_ev(KS, 3'b010, 1);
      op(3'b010);
      check("t1_txn_opcode", {61'd0, txn_opcode}, 64'd2);
      tick(4);
      done();
      check("t1_active_askmore", {63'd0, session_active}, 64'd1);
      expect_ev(KE, 3'd0, 1);
      more(1'b0);
      check("t1_active_eject", {63'd0, session_active}, 64'd0);
      tick(3);
      card_in = 1'b0;
      tick(2);
      insert();
      check("t1_back_to_idle", {63'd0, session_active}, 64'd1);
      card_in = 1'b0;
      tick(2);

      // Three wrong PINs lock the card until reset.
      insert();
      for (int i = 0; i < 2; i++) begin
         expect_ev(KP, 3'd0, 1);
         pin(BAD);
         tick(1);
      end
      check("t2_not_locked_yet", {63'd0, card_retained}, 64'd0);
      expect_ev(KP, 3'd0, 1);
      pin(BAD);
      check("t2_retained", {63'd0, card_retained}, 64'd1);
      check("t2_inactive", {63'd0, session_active}, 64'd0);
      card_in = 1'b0;
      tick(5);
      check("t2_retained_no_card", {63'd0, card_retained}, 64'd1);
      insert();
      pin(GOOD);
      tick(3);
      check("t2_locked_ignores", {62'd0, card_retained, session_active}, 64'd2);
      card_in = 1'b0;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("t2_reset_unlocks", outs(), '0);

      // Inactivity timeout in MENU, then a valid op in the expiry cycle.
      insert();
      expect_ev(KT | KE, 3'd0, TCYC + 1);
      pin(GOOD);
      tick(TCYC + 1);
      check("t3_after_timeout", {63'd0, session_active}, 64'd0);
      card_in = 1'b0;
      tick(2);
      insert();
      pin(GOOD);
      tick(TCYC - 1);
      expect_ev(KS, 3'd1, 1);
      op(3'd1);
      tick(3);
      check("t3_op_beats_timeout", {63'd0, session_active}, 64'd1);
      done();
      more(1'b1);
      expect_ev(KE, 3'd0, 1);
      op(3'd0);
      card_in = 1'b0;
      tick(2);

      // Card pulled during BUSY and in MENU.
      insert();
      pin(GOOD);
      expect_ev(KS, 3'd4, 1);
      op(3'd4);
      card_in = 1'b0;
      tick(3);
      check("t4_busy_holds", {63'd0, session_active}, 64'd1);
      done();
      check("t4_idle_after_done", {63'd0, session_active}, 64'd0);
      insert();
      pin(GOOD);
      check("t4_menu_active", {63'd0, session_active}, 64'd1);
      card_in = 1'b0;
      tick(1);
      check("t4_menu_removal", {63'd0, session_active}, 64'd0);
      tick(TCYC + 4);
      insert();
      check("t4_idle_confirmed", {63'd0, session_active}, 64'd1);
      card_in = 1'b0;
      tick(2);

      // Illegal opcode leaves the timer running; extra op in BUSY is dropped.
      insert();
      expect_ev(KT | KE, 3'd0, TCYC + 1);
      pin(GOOD);
      tick(4);
      op(3'b111);
      tick(TCYC - 3);
      check("t5_illegal_timeout", {63'd0, session_active}, 64'd0);
      card_in = 1'b0;
      tick(2);
      insert();
      pin(GOOD);
      expect_ev(KS, 3'd3, 1);
      op(3'd3);
      op(3'd5);
      tick(2);
      check("t5_busy_op_ignored", {61'd0, txn_opcode}, 64'd3);
      done();
      expect_ev(KE, 3'd0, 1);
      more(1'b0);
      card_in = 1'b0;
      tick(2);

      // Reset during BUSY aborts; a stray txn_done afterwards does nothing.
      insert();
      pin(GOOD);
      expect_ev(KS, 3'd1, 1);
      op(3'd1);
      tick(2);
      reset = 1'b1;
      card_in = 1'b0;
      tick(1);
      check("t6_reset_mid_busy", outs(), '0);
      reset = 1'b0;
      done();
      tick(1);
      check("t6_stray_done", outs(), '0);
      insert();
      check("t6_idle_confirmed", {63'd0, session_active}, 64'd1);
      card_in = 1'b0;
      tick(3);

      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
